// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered RISC-V immediate generator with a valid/ready
// handshake on both sides and a two-entry (main + skid) output buffer.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no beat held; OutValid=0, InReady=1 (after reset recovery)
// ST_ONE   | main register holds the output beat; skid register empty
// ST_FULL  | main and skid both hold beats; InReady=0
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] TagIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [XLEN-1:0]  ImmExt,
    output logic             Illegal,
    output logic [TAG_W-1:0] TagOut
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             in_ready_q;
    logic [63:0]      dec_wide;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    logic [XLEN-1:0]  main_imm, skid_imm;
    logic             main_illegal, skid_illegal;
    logic [TAG_W-1:0] main_tag, skid_tag;

    logic accept, drain;
    logic load_main, load_skid, main_from_skid;

    // The decode is built at 64 bits and truncated, so each format is written
    // once; for XLEN=32 the upper half simply falls away.
    always_comb begin
        dec_wide    = '0;
        dec_illegal = 1'b0;
        case (ImmSrc)
            3'b000: dec_wide = {{52{Instr[31]}}, Instr[31:20]};
            3'b001: dec_wide = {{52{Instr[31]}}, Instr[31:25], Instr[11:7]};
            3'b010: dec_wide = {{51{Instr[31]}}, Instr[31], Instr[7],
                                Instr[30:25], Instr[11:8], 1'b0};
            3'b011: dec_wide = {{43{Instr[31]}}, Instr[31], Instr[19:12],
                                Instr[20], Instr[30:21], 1'b0};
            3'b100: dec_wide = {{32{Instr[31]}}, Instr[31:12], 12'b0};
            3'b101: begin
                if (XLEN == 64) dec_wide = {58'b0, Instr[25:20]};
                else            dec_wide = {59'b0, Instr[24:20]};
            end
            3'b110: dec_wide = {59'b0, Instr[19:15]};
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = dec_wide[XLEN-1:0];

    // Opcode bits and the truncated upper decode bits are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{Instr[6:0], dec_wide};

    assign OutValid = (state_q != ST_EMPTY);
    assign InReady  = in_ready_q;
    assign accept   = InValid & in_ready_q;
    assign drain    = OutValid & OutReady;

    // Next-state and buffer-load decisions.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = ST_FULL;
                end else if (drain) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    main_from_skid = 1'b1;
                    state_d        = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State register; InReady is registered from the next state so it never
    // depends combinationally on OutReady, and it stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Main output register: loads only on a new beat or a skid promotion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm     <= '0;
            main_illegal <= 1'b0;
            main_tag     <= '0;
        end else if (load_main) begin
            main_imm     <= dec_imm;
            main_illegal <= dec_illegal;
            main_tag     <= TagIn;
        end else if (main_from_skid) begin
            main_imm     <= skid_imm;
            main_illegal <= skid_illegal;
            main_tag     <= skid_tag;
        end
    end

    // Skid register: catches the beat accepted while the main one is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (load_skid) begin
            skid_imm     <= dec_imm;
            skid_illegal <= dec_illegal;
            skid_tag     <= TagIn;
        end
    end

    assign ImmExt  = main_imm;
    assign Illegal = main_illegal;
    assign TagOut  = main_tag;

endmodule
